// File: rtl/conv2_channel_scheduler.sv
// Runs six input channels through one shared 5x5 engine and accumulates the valid 10x10 window.
// Build option: define CONV2_RELU_EN to clamp negative final outputs to zero.
module conv2_channel_scheduler #(
  parameter int DATA_WIDTH = 24,
  parameter int IMG_W      = 14,
  parameter int IMG_H      = 14,
  parameter int K          = 5,
  parameter int NUM_CH     = 6,
  localparam int OUT_W     = IMG_W - K + 1,
  localparam int OUT_H     = IMG_H - K + 1,
  localparam int CH_W      = $clog2(NUM_CH),
  localparam int A_W       = $clog2(OUT_W * OUT_H)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic [DATA_WIDTH-1:0] pix_in_i,
  input  logic                  pix_valid_i,
  output logic                  pix_ready_o,
  output logic [CH_W-1:0]       ch_sel_o,
  output logic                  eng_clr_o,
  output logic [DATA_WIDTH-1:0] eng_data_o,
  output logic                  eng_valid_o,
  input  logic [DATA_WIDTH-1:0] eng_out_i,
  input  logic                  eng_out_valid_i,
  output logic [DATA_WIDTH-1:0] fm_out_o,
  output logic [A_W-1:0]        fm_addr_o,
  output logic                  fm_valid_o
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int NOUT  = OUT_W * OUT_H;
  localparam int PIX_W = $clog2(NPIX + 1);
  localparam int ROW_W = $clog2(IMG_H + 1);
  localparam int COL_W = $clog2(IMG_W);

  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NPIX - 1);
  localparam logic [PIX_W-1:0] ALL_PIX  = PIX_W'(NPIX);
  localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(K - 1);
  localparam logic [COL_W-1:0] COL_MIN  = COL_W'(K - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t                 state_q;
  logic [CH_W-1:0]        ch_q;
  logic [PIX_W-1:0]       pix_cnt_q;
  logic [PIX_W-1:0]       res_cnt_q;
  logic [ROW_W-1:0]       row_q;
  logic [COL_W-1:0]       col_q;
  logic [A_W-1:0]         addr_q;
  logic                   busy_q, done_q, pix_ready_q, eng_clr_q, fm_valid_q;
  logic [DATA_WIDTH-1:0]  fm_out_q;
  logic [A_W-1:0]         fm_addr_q;
  logic [DATA_WIDTH-1:0]  buf_q [NOUT];

  logic                   pix_acc, res_act, res_keep;
  logic [DATA_WIDTH-1:0]  sum_d, fm_d;

  function automatic logic [DATA_WIDTH-1:0] sat_add(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] s;
    s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1])
      sat_add = s[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else
      sat_add = s[DATA_WIDTH-1:0];
  endfunction

  assign pix_acc  = pix_valid_i && pix_ready_q;
  assign res_act  = eng_out_valid_i && ((state_q == S_FEED) || (state_q == S_DRAIN));
  assign res_keep = res_act && (row_q >= ROW_MIN) && (col_q >= COL_MIN);
  assign sum_d    = sat_add(buf_q[addr_q], eng_out_i);

`ifdef CONV2_RELU_EN
  assign fm_d = sum_d[DATA_WIDTH-1] ? '0 : sum_d;
`else
  assign fm_d = sum_d;
`endif

  // Kept results arrive in raster order, so a running count is the buffer address.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      pix_cnt_q   <= '0;
      res_cnt_q   <= '0;
      row_q       <= '0;
      col_q       <= '0;
      addr_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pix_ready_q <= 1'b0;
      eng_clr_q   <= 1'b0;
      fm_valid_q  <= 1'b0;
      fm_out_q    <= '0;
      fm_addr_q   <= '0;
    end else begin
      done_q     <= 1'b0;
      eng_clr_q  <= 1'b0;
      fm_valid_q <= 1'b0;

      if (res_act) begin
        res_cnt_q <= res_cnt_q + 1'b1;
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
        if (res_keep) begin
          addr_q <= addr_q + 1'b1;
          if (ch_q == CH_LAST) begin
            fm_valid_q <= 1'b1;
            fm_out_q   <= fm_d;
            fm_addr_q  <= addr_q;
          end
        end
      end

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q   <= S_CLR;
            ch_q      <= '0;
            busy_q    <= 1'b1;
            eng_clr_q <= 1'b1;
          end
        end
        S_CLR: begin
          pix_cnt_q   <= '0;
          res_cnt_q   <= '0;
          row_q       <= '0;
          col_q       <= '0;
          addr_q      <= '0;
          pix_ready_q <= 1'b1;
          state_q     <= S_FEED;
        end
        S_FEED: begin
          if (pix_acc) begin
            pix_cnt_q <= pix_cnt_q + 1'b1;
            if (pix_cnt_q == LAST_PIX) begin
              pix_ready_q <= 1'b0;
              state_q     <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (res_cnt_q == ALL_PIX) begin
            if (ch_q == CH_LAST) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              ch_q      <= ch_q + 1'b1;
              state_q   <= S_CLR;
              eng_clr_q <= 1'b1;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Partial-sum storage needs no reset: channel 0 overwrites every entry.
  always_ff @(posedge clk_i) begin
    if (res_keep && (ch_q != CH_LAST))
      buf_q[addr_q] <= (ch_q == '0) ? eng_out_i : sum_d;
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pix_ready_o = pix_ready_q;
  assign ch_sel_o    = ch_q;
  assign eng_clr_o   = eng_clr_q;
  assign eng_data_o  = pix_in_i;
  assign eng_valid_o = pix_acc;
  assign fm_out_o    = fm_out_q;
  assign fm_addr_o   = fm_addr_q;
  assign fm_valid_o  = fm_valid_q;

endmodule

// File: tb/tb_conv2_channel_scheduler.sv
// Directed bench for conv2_channel_scheduler with a one-cycle-latency engine model.
module tb_conv2_channel_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done;
  logic [23:0] pix_in;
  logic        pix_valid, pix_ready;
  logic [2:0]  ch_sel;
  logic        eng_clr;
  logic [23:0] eng_data;
  logic        eng_valid;
  logic [23:0] eng_out;
  logic        eng_out_valid;
  logic [23:0] fm_out;
  logic [6:0]  fm_addr;
  logic        fm_valid;

  int n_cmp = 0;
  int n_bad = 0;

  conv2_channel_scheduler dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .busy_o         (busy),
    .done_o         (done),
    .pix_in_i       (pix_in),
    .pix_valid_i    (pix_valid),
    .pix_ready_o    (pix_ready),
    .ch_sel_o       (ch_sel),
    .eng_clr_o      (eng_clr),
    .eng_data_o     (eng_data),
    .eng_valid_o    (eng_valid),
    .eng_out_i      (eng_out),
    .eng_out_valid_i(eng_out_valid),
    .fm_out_o       (fm_out),
    .fm_addr_o      (fm_addr),
    .fm_valid_o     (fm_valid)
  );

  always #5 clk = ~clk;

  // Engine model: one result per forwarded pixel, one cycle later.
  int          eng_mode = 0;
  logic [23:0] eng_const = 24'd5;
  int          eng_idx;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_out_valid <= 1'b0;
      eng_out       <= '0;
      eng_idx       <= 0;
    end else begin
      eng_out_valid <= eng_valid;
      if (eng_clr) eng_idx <= 0;
      else if (eng_valid) begin
        eng_out <= (eng_mode == 1) ? 24'(eng_idx) : eng_const;
        eng_idx <= eng_idx + 1;
      end
    end
  end

  int          clr_cnt, clr_ch_err, fm_cnt, fm_ord_err, done_cnt, done_gap_err, rdy_err;
  logic [23:0] fm_val [100];
  logic        prev_fmv;
  always @(negedge clk) begin
    if (!rst) begin
      if (eng_clr) begin
        if (ch_sel != 3'(clr_cnt)) clr_ch_err++;
        clr_cnt++;
        if (pix_ready) rdy_err++;
      end
      if (pix_ready && !busy) rdy_err++;
      if (fm_valid) begin
        if (int'(fm_addr) != fm_cnt) fm_ord_err++;
        if (fm_cnt < 100) fm_val[fm_cnt] = fm_out;
        fm_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (!prev_fmv || busy) done_gap_err++;
      end
      prev_fmv = fm_valid;
    end
  end

  int sent, drop_err;

  task automatic clear_mon();
    clr_cnt = 0; clr_ch_err = 0; fm_cnt = 0; fm_ord_err = 0;
    done_cnt = 0; done_gap_err = 0; rdy_err = 0; prev_fmv = 0;
    sent = 0; drop_err = 0;
    for (int i = 0; i < 100; i++) fm_val[i] = 'x;
  endtask

  // Streams 6x196 pixels; optionally pulses start once mid-pass.
  task automatic drive_pass(input int pct, input bit mid_start);
    int  cyc;
    bit  expect_low, started;
    cyc = 0; expect_low = 0; started = 0;
    while (sent < 1176 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (expect_low && pix_ready) drop_err++;
      expect_low = 0;
      start = 1'b0;
      if (mid_start && !started && sent >= 300) begin
        start = 1'b1;
        started = 1;
      end
      pix_valid = ($urandom_range(99) < pct);
      pix_in    = 24'($urandom);
      if (pix_valid && pix_ready) begin
        sent++;
        if (sent % 196 == 0) expect_low = 1;
      end
    end
    @(negedge clk);
    if (expect_low && pix_ready) drop_err++;
    pix_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done_cnt == 0 && t < 3000) begin
      @(negedge clk);
      if (pix_ready) rdy_err++;
      t++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_pass(input int mode, input logic [23:0] cval, input int pct, input bit mid_start);
    eng_mode = mode; eng_const = cval;
    clear_mon();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_after_start got=%b exp=1", busy); end
    drive_pass(pct, mid_start);
    wait_done();
  endtask

  task automatic check_pass_shape(input string tag);
    n_cmp++;
    if (sent !== 1176) begin n_bad++; $display("FAIL %s pixels_sent got=%0d exp=1176", tag, sent); end
    n_cmp++;
    if (clr_cnt !== 6 || clr_ch_err !== 0) begin
      n_bad++; $display("FAIL %s eng_clr got=%0d chsel_err=%0d exp=6/0", tag, clr_cnt, clr_ch_err);
    end
    n_cmp++;
    if (fm_cnt !== 100 || fm_ord_err !== 0) begin
      n_bad++; $display("FAIL %s fm_valid got=%0d order_err=%0d exp=100/0", tag, fm_cnt, fm_ord_err);
    end
    n_cmp++;
    if (done_cnt !== 1 || done_gap_err !== 0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL %s done got=%0d gap_err=%0d busy=%b exp=1/0/0", tag, done_cnt, done_gap_err, busy);
    end
    n_cmp++;
    if (rdy_err !== 0 || drop_err !== 0) begin
      n_bad++; $display("FAIL %s pix_ready got=%0d/%0d stray exp=0/0", tag, rdy_err, drop_err);
    end
  endtask

  task automatic check_all_equal(input string tag, input logic [23:0] exp);
    int bad, first;
    bad = 0; first = -1;
    for (int i = 0; i < 100; i++)
      if (fm_val[i] !== exp) begin bad++; if (first < 0) first = i; end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL %s fm_out bad=%0d first_addr=%0d got=%h exp=%h", tag, bad, first, fm_val[first], exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_in = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, pix_ready, eng_clr, fm_valid} !== 5'b0) begin
      n_bad++; $display("FAIL reset_flags got=%b exp=00000", {busy, done, pix_ready, eng_clr, fm_valid});
    end
    n_cmp++;
    if (ch_sel !== 3'd0 || fm_addr !== 7'd0) begin
      n_bad++; $display("FAIL reset_idx got ch=%0d addr=%0d exp=0/0", ch_sel, fm_addr);
    end
    n_cmp++;
    if (fm_out !== 24'd0) begin n_bad++; $display("FAIL reset_fm_out got=%h exp=000000", fm_out); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || pix_ready !== 1'b0) begin
      n_bad++; $display("FAIL idle_no_start got busy=%b ready=%b exp=0/0", busy, pix_ready);
    end
  endtask

  task automatic test_const();
    run_pass(0, 24'd5, 100, 0);
    check_pass_shape("const5");
    check_all_equal("const5", 24'd30);
  endtask

  task automatic test_index();
    int bad, n;
    run_pass(1, 24'd0, 100, 0);
    check_pass_shape("index");
    n_cmp++;
    if (fm_val[0] !== 24'd360) begin n_bad++; $display("FAIL index_addr0 got=%0d exp=360", fm_val[0]); end
    n_cmp++;
    if (fm_val[99] !== 24'd1170) begin n_bad++; $display("FAIL index_addr99 got=%0d exp=1170", fm_val[99]); end
    bad = 0;
    for (int a = 0; a < 100; a++) begin
      n = (a / 10 + 4) * 14 + (a % 10) + 4;
      if (fm_val[a] !== 24'(6 * n)) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL index_all got bad=%0d exp=0", bad); end
  endtask

  task automatic test_saturation();
    logic [23:0] exp_neg, exp_m30;
`ifdef CONV2_RELU_EN
    exp_neg = 24'h000000; exp_m30 = 24'h000000;
`else
    exp_neg = 24'h800000; exp_m30 = 24'hFFFFE2;
`endif
    run_pass(0, 24'h3FFFFF, 100, 0);
    check_all_equal("sat_pos", 24'h7FFFFF);
    run_pass(0, 24'hC00000, 100, 0);
    check_all_equal("sat_neg", exp_neg);
    run_pass(0, 24'hFFFFFB, 100, 0);
    check_all_equal("minus5", exp_m30);
  endtask

  task automatic test_gaps();
    run_pass(0, 24'd5, 50, 1);
    check_pass_shape("gaps");
    check_all_equal("gaps", 24'd30);
    repeat (5) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || clr_cnt !== 6) begin
      n_bad++; $display("FAIL mid_start_ignored got busy=%b clr=%0d exp=0/6", busy, clr_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    eng_mode = 0; eng_const = 24'd5;
    clear_mon();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!(ch_sel == 3'd3 && sent >= 3 * 196 + 50) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      pix_valid = 1'b1;
      if (pix_valid && pix_ready) sent++;
    end
    n_cmp++;
    if (ch_sel !== 3'd3 || pix_ready !== 1'b1) begin
      n_bad++; $display("FAIL reach_ch3_feed got ch=%0d ready=%b exp=3/1", ch_sel, pix_ready);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || pix_ready !== 1'b0 || fm_valid !== 1'b0 || ch_sel !== 3'd0) begin
      n_bad++; $display("FAIL async_reset got busy=%b ready=%b fmv=%b ch=%0d exp=0/0/0/0",
                        busy, pix_ready, fm_valid, ch_sel);
    end
    pix_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_pass(0, 24'd5, 100, 0);
    check_pass_shape("after_reset");
    check_all_equal("after_reset", 24'd30);
  endtask

  initial begin
    test_reset();
    test_const();
    test_index();
    test_saturation();
    test_gaps();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv2_channel_scheduler.md
Name: conv2_channel_scheduler

Overview:
- Sequences the six input channels of the conv2 layer through one shared 5x5 convolution engine.
- Feeds each channel's 14x14 pixel stream to the engine in turn and clears the engine's line buffers between channels.
- Discards border results and accumulates the valid 10x10 partial sums across channels in an internal buffer.
- On the last channel, streams out the final feature-map values. Sits between the layer-1 pooling output and the conv2 feature-map consumer.

Parameters:
- DATA_WIDTH, 24: signed two's-complement sample width (pixels, engine results, sums).
- IMG_W, 14: input map width.
- IMG_H, 14: input map height.
- K, 5: kernel size. Output is (IMG_W-K+1) x (IMG_H-K+1) = 10x10.
- NUM_CH, 6: number of input channels accumulated.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a 6-channel pass when idle.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse after the last channel completes.
- pix_in  in  DATA_WIDTH  upstream pixel, raster order, channel-major.
- pix_valid  in  1  upstream pixel valid.
- pix_ready  out  1  scheduler accepts a pixel when pix_valid && pix_ready.
- ch_sel  out  $clog2(NUM_CH)  active channel index; selects engine weight set.
- eng_clr  out  1  one-cycle line-buffer clear to the engine.
- eng_data  out  DATA_WIDTH  pixel forwarded to the engine (pix_in, combinational).
- eng_valid  out  1  equals pix_valid && pix_ready.
- eng_out  in  DATA_WIDTH  engine result.
- eng_out_valid  in  1  engine emits exactly one result per forwarded pixel, in raster order, at fixed latency.
- fm_out  out  DATA_WIDTH  final feature-map value.
- fm_addr  out  $clog2(OUT_W*OUT_H)  raster index 0..99 of fm_out.
- fm_valid  out  1  fm_out/fm_addr valid, one cycle per value.

Behaviour:
- Reset (asynchronous, active-high):
  - Outputs: busy, done, pix_ready, eng_clr, fm_valid = 0; ch_sel, fm_out, fm_addr = 0.
  - State: FSM goes to IDLE; all counters are cleared.
  - Accumulation buffer contents are don't-care (channel 0 overwrites every entry).
- FSM states:
  - IDLE: start=1 -> CLR, with ch=0. Otherwise stay.
  - CLR: eng_clr=1 for exactly one cycle; the input and result counters reset to 0; -> FEED.
  - FEED: pix_ready=1. The input counter increments on each accepted pixel. When the counter reaches IMG_W*IMG_H-1 and that pixel is accepted -> DRAIN (pix_ready drops the next cycle).
  - DRAIN: pix_ready=0. Wait until the result counter reaches IMG_W*IMG_H.
    - If ch==NUM_CH-1 -> DONE.
    - Otherwise ch++ and -> CLR.
  - DONE: done=1 for one cycle; -> IDLE. busy falls in the same cycle done is high.
- Start handling: start in any state other than IDLE is ignored.
- Result handling (FEED and DRAIN only; eng_out_valid is ignored in IDLE, CLR and DONE):
  - Row/col counters (r, c) advance in raster order on each eng_out_valid; the result counter increments.
  - Results are kept only when r >= K-1 and c >= K-1. Buffer address a = (r-K+1)*OUT_W + (c-K+1).
  - ch==0: buf[a] <= eng_out (overwrite).
  - 0 < ch < NUM_CH-1: buf[a] <= sat_add(buf[a], eng_out).
  - ch==NUM_CH-1: the buffer is not written. fm_out <= sat_add(buf[a], eng_out), fm_addr <= a, fm_valid <= 1 on the next edge (latency 1 cycle); otherwise fm_valid=0.
- Buffer: OUT_W*OUT_H registers with combinational read, so a back-to-back result every cycle is supported (addresses are distinct).
- sat_add: signed DATA_WIDTH add that clamps to +2^(DATA_WIDTH-1)-1 or -2^(DATA_WIDTH-1) on overflow. With DATA_WIDTH=24 the limits are 0x7FFFFF and 0x800000.
- Totals per pass: exactly NUM_CH*IMG_W*IMG_H pixels consumed and exactly OUT_W*OUT_H fm_valid pulses.
- Pixel gaps: pix_valid gaps stall FEED with no effect on state.
- Reset during any state aborts the pass immediately; a new start is required.

Optional Feature:
- Macro: CONV2_RELU_EN.
- Defined: the final-channel output is ReLU'd; fm_out = 0 when the saturated sum is negative, else the sum.
- Undefined: fm_out is the raw saturated sum.
- Intermediate buffer contents are identical in both builds.

Test Plan:
- Engine model returns constant 5 per pixel; start; stream 6x196 pixels -> eng_clr pulses 6 times, 100 fm_valid pulses, fm_addr 0..99 in order, every fm_out=30, done one cycle after drain.
- Engine model returns the raster index n per result -> 6x196 results forwarded, only those with n%14 >= 4 and n/14 >= 4 used; fm_out at fm_addr 0 = 6*60 = 360; fm_addr 99 = 6*195 = 1170.
- Engine returns 0x3FFFFF every result -> fm_out=0x7FFFFF (saturated); with -0x400000 -> 0x800000 (no macro) or 0 (CONV2_RELU_EN).
- Engine returns -5 -> fm_out=0xFFFFE2 (-30) without macro; fm_out=0 with CONV2_RELU_EN.
- pix_valid toggled randomly 50% -> same results as the first scenario; pix_ready=0 throughout DRAIN/CLR; start pulsed mid-FEED ignored.
- Assert rst during FEED of channel 3 -> busy/pix_ready/fm_valid=0 asynchronously; new start gives the first scenario's results exactly.
